// File: rtl/pipeline_control.sv
// ---------------------------------------------------------------------------
// pipeline_control
//
// Control unit for a classic five-stage MIPS-subset pipeline (IF, ID, EX,
// MEM, WB). Decodes the instruction sitting in ID, carries its control word
// through registered ID/EX, EX/MEM and MEM/WB control stages, detects
// load-use / RAW hazards (no forwarding), and resolves branches and jumps in
// MEM with a three-slot flush.
//
// Ports
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low; clears all state
//   IFID_Inst    in  32   instruction currently in ID
//   IFID_Valid   in   1   ID instruction is real (0 = bubble)
//   EXMEM_Cond   in   1   branch condition of the instruction in MEM
//   CS_ALUSrc    out  1   EX: second ALU operand is the immediate
//   CS_ALUOp     out  3   EX: ALU operation (000 and, 001 or, 010 add, 110 sub)
//   CS_MemWrite  out  1   MEM: data memory write
//   CS_Branch    out  1   MEM: PC redirect (taken BEQ or J)
//   CS_RegWrite  out  1   WB: register file write
//   CS_MemToReg  out  1   WB: write-back data comes from memory
//   Stall        out  1   hold PC and IF/ID, bubble into ID/EX
//   Flush        out  1   squash IF/ID, ID/EX and EX/MEM
//   IllegalInst  out  1   sticky: an undecodable valid instruction reached ID
//   StallCount   out 16   saturating count of stalled cycles
//
// Flow control: there is no ready/valid handshake on the ID input. A stage
// holds a real instruction only when its valid bit is 1; IFID_Valid=0 marks
// a bubble. Back-pressure toward fetch is expressed solely through Stall
// (hold IF/ID) and Flush (discard IF/ID), both combinational in the current
// cycle and acted on by the datapath at the next rising edge.
//
// The control path has no multi-state FSM; its whole state is the three
// control stages plus the sticky illegal flag and the stall counter, all of
// which are visible on the ports above.
// ---------------------------------------------------------------------------
module pipeline_control #(
  // Ceiling for StallCount. The default uses the full 16-bit range.
  parameter logic [15:0] STALL_COUNT_MAX = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IFID_Inst,
  input  logic        IFID_Valid,
  input  logic        EXMEM_Cond,
  output logic        CS_ALUSrc,
  output logic [2:0]  CS_ALUOp,
  output logic        CS_MemWrite,
  output logic        CS_Branch,
  output logic        CS_RegWrite,
  output logic        CS_MemToReg,
  output logic        Stall,
  output logic        Flush,
  output logic        IllegalInst,
  output logic [15:0] StallCount
);

  // -------------------------------------------------------------------------
  // Encodings
  // -------------------------------------------------------------------------
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;

  // -------------------------------------------------------------------------
  // Control word carried down the pipe
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       is_beq;
    logic       is_jump;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] dest;       // 0 means "no destination"
  } ctrl_t;

  typedef struct packed {
    logic  valid;
    ctrl_t ctrl;
  } stage_t;

  stage_t idex_q, exmem_q, memwb_q;
  stage_t idex_d, exmem_d, memwb_d;

  // -------------------------------------------------------------------------
  // ID decode
  // -------------------------------------------------------------------------
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = IFID_Inst[31:26];
  assign rs     = IFID_Inst[25:21];
  assign rt     = IFID_Inst[20:16];
  assign rd     = IFID_Inst[15:11];
  assign funct  = IFID_Inst[5:0];

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  logic  dec_use_rs;
  logic  dec_use_rt;

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    dec_use_rs  = 1'b0;
    dec_use_rt  = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        dec_use_rs         = 1'b1;
        dec_use_rt         = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.dest      = rd;
        case (funct)
          FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
          FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
          FN_AND:  dec_ctrl.alu_op = ALU_AND;
          FN_OR:   dec_ctrl.alu_op = ALU_OR;
          default: dec_illegal     = 1'b1;
        endcase
      end
      OP_LW: begin
        dec_use_rs          = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.alu_op     = ALU_ADD;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.dest       = rt;
      end
      OP_SW: begin
        dec_use_rs         = 1'b1;
        dec_use_rt         = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        dec_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_use_rs      = 1'b1;
        dec_use_rt      = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
        dec_ctrl.is_beq = 1'b1;
      end
      OP_ADDI: begin
        dec_use_rs         = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.dest      = rt;
      end
      OP_J: begin
        dec_ctrl.is_jump = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase

    // An undecodable instruction contributes no controls and no sources.
    if (dec_illegal) begin
      dec_ctrl   = '0;
      dec_use_rs = 1'b0;
      dec_use_rt = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Hazard detection and branch resolution
  // -------------------------------------------------------------------------
  // A stage blocks a source register when it holds a valid instruction whose
  // nonzero destination equals that register. The register file writes in
  // the first half of the cycle, so MEM/WB never needs to be checked.
  function automatic logic dest_hit(input stage_t s, input logic [4:0] r);
    return s.valid && (s.ctrl.dest != 5'd0) && (s.ctrl.dest == r);
  endfunction

  logic rs_blocked;
  logic rt_blocked;
  logic raw_hazard;
  logic branch_taken;

  assign rs_blocked = dec_use_rs && (dest_hit(idex_q, rs) || dest_hit(exmem_q, rs));
  assign rt_blocked = dec_use_rt && (dest_hit(idex_q, rt) || dest_hit(exmem_q, rt));
  assign raw_hazard = IFID_Valid && (rs_blocked || rt_blocked);

  assign branch_taken = exmem_q.valid &&
                        (exmem_q.ctrl.is_jump || (exmem_q.ctrl.is_beq && EXMEM_Cond));

  // A redirect discards the ID instruction anyway, so it overrides a stall.
  assign Flush     = branch_taken;
  assign CS_Branch = branch_taken;
  assign Stall     = raw_hazard && !branch_taken;

  // -------------------------------------------------------------------------
  // Next-state for the control stages
  // -------------------------------------------------------------------------
  always_comb begin
    idex_d  = '0;
    exmem_d = '0;
    memwb_d = '0;

    // ID/EX takes the decoded word unless it is a bubble, illegal, stalled
    // or squashed; in all those cases it receives an all-zero bubble.
    if (IFID_Valid && !dec_illegal && !Stall && !branch_taken) begin
      idex_d.valid = 1'b1;
      idex_d.ctrl  = dec_ctrl;
    end

    // EX/MEM advances during a stall and is squashed on a redirect.
    if (!branch_taken) begin
      exmem_d = idex_q;
    end

    // MEM/WB always advances; on a redirect it receives the branch itself.
    memwb_d = exmem_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky illegal flag and saturating stall counter
  // -------------------------------------------------------------------------
  // A wrong-path instruction being flushed out of ID is not reported.
  logic illegal_q;
  logic [15:0] stall_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else if (IFID_Valid && dec_illegal && !branch_taken) begin
      illegal_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_q <= 16'd0;
    end else if (Stall && (stall_count_q != STALL_COUNT_MAX)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign IllegalInst = illegal_q;
  assign StallCount  = stall_count_q;

  // -------------------------------------------------------------------------
  // Stage-qualified control outputs
  // -------------------------------------------------------------------------
  assign CS_ALUSrc   = idex_q.valid  && idex_q.ctrl.alu_src;
  assign CS_ALUOp    = idex_q.valid  ?  idex_q.ctrl.alu_op : 3'b000;
  assign CS_MemWrite = exmem_q.valid && exmem_q.ctrl.mem_write;
  assign CS_RegWrite = memwb_q.valid && memwb_q.ctrl.reg_write;
  assign CS_MemToReg = memwb_q.valid && memwb_q.ctrl.mem_to_reg;

  // Shamt and the MEM/WB fields that WB does not consume.
  logic unused_bits;
  assign unused_bits = ^{IFID_Inst[10:6],
                         memwb_q.ctrl.alu_src, memwb_q.ctrl.alu_op,
                         memwb_q.ctrl.mem_write, memwb_q.ctrl.is_beq,
                         memwb_q.ctrl.is_jump, memwb_q.ctrl.dest};

endmodule

// File: tb/tb_pipeline_control.sv
// ---------------------------------------------------------------------------
// tb_pipeline_control
//
// Directed bench for pipeline_control. Each scenario task drives the ID
// inputs, advances the clock and compares the DUT outputs against values
// worked out by hand from the instruction encodings. The stall counter
// ceiling is lowered so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_pipeline_control;

  localparam logic [15:0] SAT = 16'h0040;

  // Hand-assembled instructions
  localparam logic [31:0] I_ADD_3_1_2 = 32'h00221820; // add  $3,$1,$2
  localparam logic [31:0] I_SUB_4_1_2 = 32'h00222022; // sub  $4,$1,$2
  localparam logic [31:0] I_AND_5_1_2 = 32'h00222824; // and  $5,$1,$2
  localparam logic [31:0] I_OR_6_1_2  = 32'h00223025; // or   $6,$1,$2
  localparam logic [31:0] I_ADD_2_1_1 = 32'h00211020; // add  $2,$1,$1
  localparam logic [31:0] I_LW_1_0    = 32'h8C010000; // lw   $1,0($0)
  localparam logic [31:0] I_LW_7_0    = 32'h8C070000; // lw   $7,0($0)
  localparam logic [31:0] I_LW_1_2    = 32'h8C410000; // lw   $1,0($2)
  localparam logic [31:0] I_LW_2_1    = 32'h8C220000; // lw   $2,0($1)
  localparam logic [31:0] I_SW_6_0    = 32'hAC060000; // sw   $6,0($0)
  localparam logic [31:0] I_SW_5_0    = 32'hAC050000; // sw   $5,0($0)
  localparam logic [31:0] I_ADDI_5    = 32'h20050001; // addi $5,$0,1
  localparam logic [31:0] I_BEQ       = 32'h10000004; // beq  $0,$0,4
  localparam logic [31:0] I_J         = 32'h08000000; // j    0
  localparam logic [31:0] I_BAD_OP    = 32'hFC000000; // opcode 0x3F
  localparam logic [31:0] I_BAD_FN    = 32'h00221821; // funct 100001

  // ---------------- clock / reset ----------------
  logic        clock;
  logic        reset;
  logic [31:0] IFID_Inst;
  logic        IFID_Valid;
  logic        EXMEM_Cond;
  logic        CS_ALUSrc;
  logic [2:0]  CS_ALUOp;
  logic        CS_MemWrite;
  logic        CS_Branch;
  logic        CS_RegWrite;
  logic        CS_MemToReg;
  logic        Stall;
  logic        Flush;
  logic        IllegalInst;
  logic [15:0] StallCount;

  int checks   = 0;
  int failures = 0;

  // Expected EX-stage ALU op stream for back-to-back R-types
  logic [2:0] exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  pipeline_control #(.STALL_COUNT_MAX(SAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .IFID_Inst   (IFID_Inst),
    .IFID_Valid  (IFID_Valid),
    .EXMEM_Cond  (EXMEM_Cond),
    .CS_ALUSrc   (CS_ALUSrc),
    .CS_ALUOp    (CS_ALUOp),
    .CS_MemWrite (CS_MemWrite),
    .CS_Branch   (CS_Branch),
    .CS_RegWrite (CS_RegWrite),
    .CS_MemToReg (CS_MemToReg),
    .Stall       (Stall),
    .Flush       (Flush),
    .IllegalInst (IllegalInst),
    .StallCount  (StallCount)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_id(input logic [31:0] inst, input logic valid);
    IFID_Inst  = inst;
    IFID_Valid = valid;
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    IFID_Valid = 1'b0;
    IFID_Inst  = 32'h0;
    EXMEM_Cond = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset      = 1'b0;
    IFID_Inst  = I_ADD_2_1_1;
    IFID_Valid = 1'b1;
    EXMEM_Cond = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if ({CS_ALUSrc, CS_ALUOp, CS_MemWrite, CS_Branch, CS_RegWrite, CS_MemToReg} !== 8'h00) begin
      failures++; $display("FAIL reset_cs: got %0h want 0", {CS_ALUSrc, CS_ALUOp, CS_MemWrite, CS_Branch, CS_RegWrite, CS_MemToReg}); end
    checks++; if ({Stall, Flush, IllegalInst} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %0b want 000", {Stall, Flush, IllegalInst}); end
    checks++; if (StallCount !== 16'h0000) begin
      failures++; $display("FAIL reset_count: got %0h want 0", StallCount); end
    @(negedge clock);
    reset      = 1'b1;
    IFID_Valid = 1'b0;
    EXMEM_Cond = 1'b0;
    #1;
    checks++; if ({Stall, Flush} !== 2'b00) begin
      failures++; $display("FAIL reset_release: got %0b want 00", {Stall, Flush}); end
  endtask

  task automatic test_add_decode();
    apply_reset();
    drive_id(I_ADD_3_1_2, 1'b1);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL add_nostall: got %0b want 0", Stall); end
    tick();
    checks++; if (CS_ALUOp !== 3'b010) begin failures++; $display("FAIL add_aluop: got %0b want 010", CS_ALUOp); end
    checks++; if (CS_ALUSrc !== 1'b0) begin failures++; $display("FAIL add_alusrc: got %0b want 0", CS_ALUSrc); end
    drive_id(32'h0, 1'b0);
    tick();
    checks++; if (CS_MemWrite !== 1'b0) begin failures++; $display("FAIL add_memwrite: got %0b want 0", CS_MemWrite); end
    checks++; if (CS_RegWrite !== 1'b0) begin failures++; $display("FAIL add_early_wb: got %0b want 0", CS_RegWrite); end
    tick();
    checks++; if (CS_RegWrite !== 1'b1) begin failures++; $display("FAIL add_regwrite: got %0b want 1", CS_RegWrite); end
    checks++; if (CS_MemToReg !== 1'b0) begin failures++; $display("FAIL add_memtoreg: got %0b want 0", CS_MemToReg); end
    tick();
    checks++; if (CS_RegWrite !== 1'b0) begin failures++; $display("FAIL add_wb_drain: got %0b want 0", CS_RegWrite); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [4];
    logic [2:0]  exp;
    vec[0] = I_ADD_3_1_2; vec[1] = I_SUB_4_1_2; vec[2] = I_AND_5_1_2; vec[3] = I_OR_6_1_2;
    exp_q.push_back(3'b010); exp_q.push_back(3'b110);
    exp_q.push_back(3'b000); exp_q.push_back(3'b001);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_id(vec[i], 1'b1);
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL b2b_stall[%0d]: got %0b want 0", i, Stall); end
      tick();
      exp = exp_q.pop_front();
      checks++; if ({CS_ALUSrc, CS_ALUOp} !== {1'b0, exp}) begin
        failures++; $display("FAIL b2b_ex[%0d]: got %0b want %0b", i, {CS_ALUSrc, CS_ALUOp}, {1'b0, exp}); end
    end
    drive_id(32'h0, 1'b0);
    tick();
    checks++; if (CS_ALUOp !== 3'b000) begin failures++; $display("FAIL b2b_bubble_aluop: got %0b want 000", CS_ALUOp); end
  endtask

  task automatic test_mem_ops();
    apply_reset();
    drive_id(I_LW_7_0, 1'b1);
    tick();
    checks++; if ({CS_ALUSrc, CS_ALUOp} !== 4'b1010) begin failures++; $display("FAIL lw_ex: got %0b want 1010", {CS_ALUSrc, CS_ALUOp}); end
    drive_id(I_SW_6_0, 1'b1);
    tick();
    checks++; if ({CS_ALUSrc, CS_MemWrite} !== 2'b10) begin failures++; $display("FAIL sw_ex_lw_mem: got %0b want 10", {CS_ALUSrc, CS_MemWrite}); end
    drive_id(I_ADDI_5, 1'b1);
    tick();
    checks++; if ({CS_ALUSrc, CS_MemWrite, CS_RegWrite, CS_MemToReg} !== 4'b1111) begin
      failures++; $display("FAIL addi_ex_sw_mem_lw_wb: got %0b want 1111", {CS_ALUSrc, CS_MemWrite, CS_RegWrite, CS_MemToReg}); end
    drive_id(32'h0, 1'b0);
    tick();
    checks++; if ({CS_MemWrite, CS_RegWrite} !== 2'b00) begin failures++; $display("FAIL addi_mem_sw_wb: got %0b want 00", {CS_MemWrite, CS_RegWrite}); end
    tick();
    checks++; if ({CS_RegWrite, CS_MemToReg} !== 2'b10) begin failures++; $display("FAIL addi_wb: got %0b want 10", {CS_RegWrite, CS_MemToReg}); end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive_id(I_LW_1_0, 1'b1);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lu_lw_nostall: got %0b want 0", Stall); end
    tick();
    drive_id(I_ADD_2_1_1, 1'b1);
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL lu_stall1: got %0b want 1", Stall); end
    tick();
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL lu_stall2: got %0b want 1", Stall); end
    checks++; if (StallCount !== 16'd1) begin failures++; $display("FAIL lu_count1: got %0d want 1", StallCount); end
    tick();
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lu_release: got %0b want 0", Stall); end
    checks++; if (StallCount !== 16'd2) begin failures++; $display("FAIL lu_count2: got %0d want 2", StallCount); end
    checks++; if ({CS_RegWrite, CS_MemToReg, CS_ALUOp} !== 5'b11000) begin
      failures++; $display("FAIL lu_lw_wb_ex_bubble: got %0b want 11000", {CS_RegWrite, CS_MemToReg, CS_ALUOp}); end
    tick();
    drive_id(32'h0, 1'b0);
    checks++; if (CS_ALUOp !== 3'b010) begin failures++; $display("FAIL lu_add_ex: got %0b want 010", CS_ALUOp); end
    checks++; if (StallCount !== 16'd2) begin failures++; $display("FAIL lu_count_hold: got %0d want 2", StallCount); end
  endtask

  task automatic test_branch_flush();
    apply_reset();
    drive_id(I_BEQ, 1'b1);
    tick();
    drive_id(I_ADDI_5, 1'b1);
    tick();
    // BEQ in MEM, ADDI ($5) in EX, SW reading $5 in ID
    EXMEM_Cond = 1'b1;
    drive_id(I_SW_5_0, 1'b1);
    checks++; if ({CS_Branch, Flush} !== 2'b11) begin failures++; $display("FAIL br_taken: got %0b want 11", {CS_Branch, Flush}); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL br_stall_prio: got %0b want 0", Stall); end
    tick();
    EXMEM_Cond = 1'b0;
    drive_id(32'h0, 1'b0);
    checks++; if ({CS_Branch, Flush} !== 2'b00) begin failures++; $display("FAIL br_one_cycle: got %0b want 00", {CS_Branch, Flush}); end
    checks++; if ({CS_MemWrite, CS_RegWrite} !== 2'b00) begin failures++; $display("FAIL br_squash1: got %0b want 00", {CS_MemWrite, CS_RegWrite}); end
    tick();
    checks++; if ({CS_MemWrite, CS_RegWrite} !== 2'b00) begin failures++; $display("FAIL br_squash2: got %0b want 00", {CS_MemWrite, CS_RegWrite}); end
    checks++; if (StallCount !== 16'd0) begin failures++; $display("FAIL br_no_stall_count: got %0d want 0", StallCount); end
  endtask

  task automatic test_jump_and_not_taken();
    apply_reset();
    drive_id(I_J, 1'b1);
    tick();
    drive_id(32'h0, 1'b0);
    tick();
    checks++; if ({CS_Branch, Flush} !== 2'b11) begin failures++; $display("FAIL j_redirect: got %0b want 11", {CS_Branch, Flush}); end
    tick();
    checks++; if (CS_Branch !== 1'b0) begin failures++; $display("FAIL j_one_cycle: got %0b want 0", CS_Branch); end
    drive_id(I_BEQ, 1'b1);
    tick();
    drive_id(32'h0, 1'b0);
    tick();
    checks++; if ({CS_Branch, Flush} !== 2'b00) begin failures++; $display("FAIL beq_not_taken: got %0b want 00", {CS_Branch, Flush}); end
    tick();
  endtask

  task automatic test_bubble();
    apply_reset();
    drive_id(I_BAD_OP, 1'b0);
    tick();
    checks++; if (IllegalInst !== 1'b0) begin failures++; $display("FAIL bubble_illegal: got %0b want 0", IllegalInst); end
    drive_id(I_LW_1_0, 1'b1);
    tick();
    drive_id(I_ADD_2_1_1, 1'b0);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL bubble_no_hazard: got %0b want 0", Stall); end
    tick();
    checks++; if (CS_ALUOp !== 3'b000) begin failures++; $display("FAIL bubble_ex: got %0b want 000", CS_ALUOp); end
  endtask

  task automatic test_illegal();
    apply_reset();
    drive_id(I_BAD_OP, 1'b1);
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL ill_stall: got %0b want 0", Stall); end
    tick();
    drive_id(32'h0, 1'b0);
    checks++; if (IllegalInst !== 1'b1) begin failures++; $display("FAIL ill_set: got %0b want 1", IllegalInst); end
    checks++; if ({CS_ALUSrc, CS_ALUOp} !== 4'b0000) begin failures++; $display("FAIL ill_ex: got %0b want 0000", {CS_ALUSrc, CS_ALUOp}); end
    tick();
    checks++; if ({CS_MemWrite, CS_Branch} !== 2'b00) begin failures++; $display("FAIL ill_mem: got %0b want 00", {CS_MemWrite, CS_Branch}); end
    tick();
    checks++; if ({CS_RegWrite, CS_MemToReg} !== 2'b00) begin failures++; $display("FAIL ill_wb: got %0b want 00", {CS_RegWrite, CS_MemToReg}); end
    repeat (5) tick();
    checks++; if (IllegalInst !== 1'b1) begin failures++; $display("FAIL ill_sticky: got %0b want 1", IllegalInst); end
    apply_reset();
    checks++; if (IllegalInst !== 1'b0) begin failures++; $display("FAIL ill_reset_clear: got %0b want 0", IllegalInst); end
    drive_id(I_BAD_FN, 1'b1);
    tick();
    drive_id(32'h0, 1'b0);
    checks++; if ({IllegalInst, CS_ALUOp} !== 4'b1000) begin failures++; $display("FAIL ill_funct: got %0b want 1000", {IllegalInst, CS_ALUOp}); end
  endtask

  // Alternating lw $1,0($2) / lw $2,0($1): each one after the first waits
  // two cycles for its predecessor, so stalls accrue 2 per instruction.
  task automatic test_stall_saturation();
    logic [15:0] exp_cnt;
    apply_reset();
    drive_id(I_LW_1_2, 1'b1);
    tick();
    for (int n = 2; n <= 50; n++) begin
      drive_id((n % 2 == 0) ? I_LW_2_1 : I_LW_1_2, 1'b1);
      checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL sat_stall_a[%0d]: got %0b want 1", n, Stall); end
      tick();
      checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL sat_stall_b[%0d]: got %0b want 1", n, Stall); end
      tick();
      checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL sat_stall_c[%0d]: got %0b want 0", n, Stall); end
      exp_cnt = (2 * (n - 1) > int'(SAT)) ? SAT : 16'(2 * (n - 1));
      checks++; if (StallCount !== exp_cnt) begin failures++; $display("FAIL sat_count[%0d]: got %0d want %0d", n, StallCount, exp_cnt); end
      tick();
    end
    drive_id(32'h0, 1'b0);
    repeat (3) tick();
    checks++; if (StallCount !== SAT) begin failures++; $display("FAIL sat_hold: got %0h want %0h", StallCount, SAT); end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    drive_id(I_LW_1_0, 1'b1);
    tick();
    drive_id(I_ADD_2_1_1, 1'b1);
    tick();
    checks++; if ({Stall, StallCount} !== {1'b1, 16'd1}) begin
      failures++; $display("FAIL mid_pre: got %0b/%0d want 1/1", Stall, StallCount); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({CS_ALUSrc, CS_ALUOp, CS_MemWrite, CS_Branch, CS_RegWrite, CS_MemToReg} !== 8'h00) begin
      failures++; $display("FAIL mid_async_cs: got %0h want 0", {CS_ALUSrc, CS_ALUOp, CS_MemWrite, CS_Branch, CS_RegWrite, CS_MemToReg}); end
    checks++; if ({Stall, Flush, IllegalInst, StallCount} !== 19'd0) begin
      failures++; $display("FAIL mid_async_flags: got %0b/%0d want 0/0", {Stall, Flush, IllegalInst}, StallCount); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL mid_post_stall: got %0b want 0", Stall); end
    tick();
    drive_id(32'h0, 1'b0);
    checks++; if ({CS_ALUOp, CS_MemWrite, CS_RegWrite} !== 5'b01000) begin
      failures++; $display("FAIL mid_post_pipe: got %0b want 01000", {CS_ALUOp, CS_MemWrite, CS_RegWrite}); end
    checks++; if (StallCount !== 16'd0) begin failures++; $display("FAIL mid_post_count: got %0d want 0", StallCount); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset      = 1'b0;
    IFID_Inst  = 32'h0;
    IFID_Valid = 1'b0;
    EXMEM_Cond = 1'b0;
    test_reset();
    test_add_decode();
    test_back_to_back();
    test_mem_ops();
    test_load_use();
    test_branch_flush();
    test_jump_and_not_taken();
    test_bubble();
    test_illegal();
    test_stall_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
